// File: rtl/ordena_pkg.sv
// Shared types and constants for the sequenced 8-word sorter.
package ordena_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int WIDTH = 8;
  localparam int N     = 8;

  localparam logic CRESC   = 1'b0;
  localparam logic DECRESC = 1'b1;

endpackage

// File: rtl/ordena_sequencial_troca_par.sv
// Combinational compare-exchange cell: lo/hi come out in the requested order.
module troca_par
  import ordena_pkg::*;
#(
  parameter int WIDTH = ordena_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ord,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  // Strict comparison only, so equal words always stay where they are.
  assign swap = (ord == DECRESC) ? (a < b) : (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/ordena_sequencial.sv
// Framed sorter: load N words, odd-even transposition sort over N cycles, then stream out.
module ordena_sequencial
  import ordena_pkg::*;
#(
  parameter int WIDTH = ordena_pkg::WIDTH,
  parameter int N     = ordena_pkg::N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cresc_ou_decres,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ord_q, ord_d;
  logic [WIDTH-1:0]  r_q [N];
  logic [WIDTH-1:0]  r_d [N];

  logic [WIDTH-1:0]  cellA  [N/2];
  logic [WIDTH-1:0]  cellB  [N/2];
  logic [WIDTH-1:0]  cellLo [N/2];
  logic [WIDTH-1:0]  cellHi [N/2];

  logic inFire, outFire;

  // Odd phases shift every cell up by one word; the last cell has no odd pair and is ignored then.
  for (genvar k = 0; k < N/2; k++) begin : g_cell
    if (k < N/2 - 1) begin : g_mid
      assign cellA[k] = idx_q[0] ? r_q[2*k+1] : r_q[2*k];
      assign cellB[k] = idx_q[0] ? r_q[2*k+2] : r_q[2*k+1];
    end else begin : g_end
      assign cellA[k] = r_q[2*k];
      assign cellB[k] = r_q[2*k+1];
    end

    troca_par #(.WIDTH(WIDTH)) u_troca (
      .a  (cellA[k]),
      .b  (cellB[k]),
      .ord(ord_q),
      .lo (cellLo[k]),
      .hi (cellHi[k])
    );
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign out_last  = (state_q == OUT) && (idx_q == LAST_IDX);
  assign out_data  = (state_q == OUT) ? r_q[idx_q] : '0;
  assign busy      = (state_q != LOAD);

  assign inFire  = in_valid && in_ready;
  assign outFire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ord_d   = ord_q;
    r_d     = r_q;
    unique case (state_q)
      LOAD: begin
        if (inFire) begin
          r_d[idx_q] = in_data;
          if (idx_q == '0) ord_d = cresc_ou_decres;
          if (idx_q == LAST_IDX) begin
            state_d = SORT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      SORT: begin
        if (!idx_q[0]) begin
          for (int k = 0; k < N/2; k++) begin
            r_d[2*k]   = cellLo[k];
            r_d[2*k+1] = cellHi[k];
          end
        end else begin
          for (int k = 0; k < N/2 - 1; k++) begin
            r_d[2*k+1] = cellLo[k];
            r_d[2*k+2] = cellHi[k];
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = OUT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      OUT: begin
        if (outFire) begin
          if (idx_q == LAST_IDX) begin
            state_d = LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      ord_q   <= CRESC;
      for (int i = 0; i < N; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ord_q   <= ord_d;
      for (int i = 0; i < N; i++) r_q[i] <= r_d[i];
    end
  end

endmodule

// File: tb/tb_ordena_sequencial.sv
// Directed, self-checking bench for ordena_sequencial: table-driven frames plus stall and reset sequences.
module tb_ordena_sequencial;

  logic       clk = 1'b0;
  logic       rst;
  logic       cresc_ou_decres;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0][7:0] w;
    logic            ord;
    logic            eq;
    logic [7:0][7:0] exp;
  } vec_t;

  vec_t vecs [4];

  ordena_sequencial dut (
    .clk            (clk),
    .rst            (rst),
    .cresc_ou_decres(cresc_ou_decres),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0][7:0] mk8(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
    logic [7:0][7:0] v;
    v[0] = a0[7:0]; v[1] = a1[7:0]; v[2] = a2[7:0]; v[3] = a3[7:0];
    v[4] = a4[7:0]; v[5] = a5[7:0]; v[6] = a6[7:0]; v[7] = a7[7:0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loads a frame, then waits for out_valid; returns at the first negedge with out_valid high.
  task automatic applyStimulus(input logic [7:0][7:0] w, input logic ordFirst, input bit toggle,
                               input bit measure, input bit eqCheck);
    int cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid        = 1'b1;
      in_data         = w[i];
      cresc_ou_decres = (i == 0 || !toggle) ? ordFirst : ~ordFirst;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    checkOutput("busy_in_sort", busy, 1);
    checkOutput("in_ready_in_sort", in_ready, 0);
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      if (eqCheck)
        for (int i = 0; i < 8; i++) checkOutput($sformatf("r_equal[%0d]", i), dut.r_q[i], 7);
      @(negedge clk);
      cnt++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
    if (measure) checkOutput("latency", cnt, 9);
  endtask

  task automatic drainFrame(input logic [7:0][7:0] exp, input bit stall);
    int n = 0;
    int cyc = 0;
    logic [7:0] held = 8'd0;
    bit stalled = 1'b0;
    while (n < 8 && cyc < 200) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (out_valid) begin
        if (stalled) checkOutput("stall_hold", out_data, held);
        if (stall) checkOutput("in_ready_in_out", in_ready, 0);
        if (out_ready) begin
          checkOutput($sformatf("data[%0d]", n), out_data, exp[n]);
          checkOutput($sformatf("last[%0d]", n), out_last, (n == 7));
          n++;
          stalled = 1'b0;
        end else begin
          held    = out_data;
          stalled = 1'b1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (n < 8) checkOutput("drain_timeout", n, 8);
    checkOutput("in_ready_after_last", in_ready, 1);
    checkOutput("out_valid_after_last", out_valid, 0);
  endtask

  initial begin
    vecs[0].w = mk8(1, 2, 3, 4, 5, 6, 7, 8); vecs[0].ord = 1'b0; vecs[0].eq = 1'b0;
    vecs[0].exp = mk8(1, 2, 3, 4, 5, 6, 7, 8);
    vecs[1].w = mk8(8, 7, 6, 5, 4, 3, 2, 1); vecs[1].ord = 1'b0; vecs[1].eq = 1'b0;
    vecs[1].exp = mk8(1, 2, 3, 4, 5, 6, 7, 8);
    vecs[2].w = mk8(8, 7, 6, 5, 4, 3, 2, 1); vecs[2].ord = 1'b1; vecs[2].eq = 1'b0;
    vecs[2].exp = mk8(8, 7, 6, 5, 4, 3, 2, 1);
    vecs[3].w = mk8(7, 7, 7, 7, 7, 7, 7, 7); vecs[3].ord = 1'b0; vecs[3].eq = 1'b1;
    vecs[3].exp = mk8(7, 7, 7, 7, 7, 7, 7, 7);

    rst             = 1'b1;
    in_valid        = 1'b0;
    in_data         = 8'd0;
    out_ready       = 1'b1;
    cresc_ou_decres = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_busy", busy, 0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].w, vecs[v].ord, 1'b0, (v == 0), vecs[v].eq);
      drainFrame(vecs[v].exp, 1'b0);
    end

    applyStimulus(mk8(3, 0, 12, 100, 45, 9, 255, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    drainFrame(mk8(0, 0, 3, 9, 12, 45, 100, 255), 1'b1);

    applyStimulus(mk8(4, 8, 1, 6, 2, 7, 3, 5), 1'b0, 1'b1, 1'b0, 1'b0);
    drainFrame(mk8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
    applyStimulus(mk8(4, 8, 1, 6, 2, 7, 3, 5), 1'b1, 1'b0, 1'b0, 1'b0);
    drainFrame(mk8(8, 7, 6, 5, 4, 3, 2, 1), 1'b0);

    // Abort a frame at SORT phase 3 and confirm everything is back at reset values.
    cresc_ou_decres = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(9 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("abort_phase", dut.idx_q, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_busy", busy, 0);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("abort_r[%0d]", i), dut.r_q[i], 0);

    applyStimulus(mk8(5, 1, 4, 2, 8, 7, 6, 3), 1'b0, 1'b0, 1'b0, 1'b0);
    drainFrame(mk8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
